// File: rtl/vec_mul_sched_pkg.sv
// Shared types and default sizing for the vector multiply scheduler.
package vec_mul_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_BIT_WIDTH = 8;
    localparam int DEF_LENGTH    = 32;
    localparam int DEF_LANES     = 8;

endpackage

// File: rtl/vec_mul_i8.sv
// Elementwise unsigned multiplier: o_prd[i] = i_a[i] * i_b[i], purely combinational.
module vec_mul_i8 #(
    parameter int bit_width = 8,
    parameter int length    = 8,
    parameter int prd_width = 2*bit_width
) (
    input  logic [length*bit_width-1:0] i_a,
    input  logic [length*bit_width-1:0] i_b,
    output logic [length*prd_width-1:0] o_prd
);

    for (genvar g = 0; g < length; g++) begin : g_elem
        // Widen both operands before multiplying so the product keeps every bit.
        assign o_prd[g*prd_width +: prd_width] =
            prd_width'(i_a[g*bit_width +: bit_width]) * prd_width'(i_b[g*bit_width +: bit_width]);
    end

endmodule

// File: rtl/vec_mul_sched.sv
// Time-multiplexed vector multiply: a lanes-wide multiplier array processes one
// chunk of the captured operands per cycle, then holds the result until taken.
module vec_mul_sched
    import vec_mul_sched_pkg::*;
#(
    parameter int bit_width = DEF_BIT_WIDTH,
    parameter int length    = DEF_LENGTH,
    parameter int lanes     = DEF_LANES,
    parameter int prd_width = 2*bit_width
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [length*bit_width-1:0] i_vec_a,
    input  logic [length*bit_width-1:0] i_vec_b,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic [length*prd_width-1:0] o_prd,
    output logic                        o_valid,
    input  logic                        i_ready,
    input  logic                        i_clear,
    output logic                        o_busy
);

    localparam int NCH     = length / lanes;
    localparam int CNT_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CHUNK_A = lanes * bit_width;
    localparam int CHUNK_P = lanes * prd_width;

    // Chunking only works when the vector splits evenly across the lanes.
    if ((length % lanes) != 0) begin : g_bad_cfg
        $error("vec_mul_sched: length must be an integer multiple of lanes");
    end

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            w_cnt_nxt;
    logic [length*bit_width-1:0] r_op_a;
    logic [length*bit_width-1:0] r_op_b;
    logic [length*prd_width-1:0] r_prd;
    logic                        w_capture;
    logic                        w_write;
    logic [CHUNK_A-1:0]          w_chunk_a;
    logic [CHUNK_A-1:0]          w_chunk_b;
    logic [CHUNK_P-1:0]          w_chunk_p;

    // State and chunk counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; clear overrides every handshake and every state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_write     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    w_state_nxt = ST_MUL;
                    w_cnt_nxt   = '0;
                    w_capture   = 1'b1;
                end
            end
            ST_MUL: begin
                w_write = 1'b1;
                if (r_cnt == CNT_W'(NCH-1)) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                if (i_ready) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (i_clear) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_capture   = 1'b0;
            w_write     = 1'b0;
        end
    end

    // Operand capture on input handshake; later input changes are ignored.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op_a <= '0;
            r_op_b <= '0;
        end else if (w_capture) begin
            r_op_a <= i_vec_a;
            r_op_b <= i_vec_b;
        end
    end

    // Select the current chunk of both operands for the shared lane array.
    always_comb begin
        w_chunk_a = '0;
        w_chunk_b = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_chunk_a = r_op_a[k*CHUNK_A +: CHUNK_A];
                w_chunk_b = r_op_b[k*CHUNK_A +: CHUNK_A];
            end
        end
    end

    vec_mul_i8 #(
        .bit_width (bit_width),
        .length    (lanes),
        .prd_width (prd_width)
    ) u_lanes (
        .i_a   (w_chunk_a),
        .i_b   (w_chunk_b),
        .o_prd (w_chunk_p)
    );

    // Write the lane products into the matching result slots each MUL cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prd <= '0;
        end else if (w_write) begin
            for (int k = 0; k < NCH; k++) begin
                if (r_cnt == CNT_W'(k)) r_prd[k*CHUNK_P +: CHUNK_P] <= w_chunk_p;
            end
        end
    end

    assign o_prd   = r_prd;
    assign o_ready = (r_state == ST_IDLE);
    assign o_valid = (r_state == ST_DONE);
    assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_vec_mul_sched.sv
// Directed bench for vec_mul_sched with a scoreboard of expected product vectors.
module tb_vec_mul_sched;

    localparam int BW  = 8;
    localparam int LEN = 32;
    localparam int LN  = 8;
    localparam int PW  = 16;

    typedef logic [LEN*PW-1:0] prd_t;
    typedef logic [LEN*BW-1:0] opv_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    opv_t i_vec_a = '0;
    opv_t i_vec_b = '0;
    logic i_valid = 1'b0;
    logic i_ready = 1'b0;
    logic i_clear = 1'b0;
    logic o_ready, o_valid, o_busy;
    prd_t o_prd;

    vec_mul_sched #(.bit_width(BW), .length(LEN), .lanes(LN), .prd_width(PW)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_vec_a (i_vec_a),
        .i_vec_b (i_vec_b),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_prd   (o_prd),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .i_clear (i_clear),
        .o_busy  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    prd_t q[$];
    prd_t last_exp = '0;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_hs  = 0;
    int   hs_gap   = 0;
    int   hs_cnt   = 0;
    bit   hs_now   = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic prd_t model(input opv_t a, input opv_t b);
        prd_t r;
        int   x, y;
        r = '0;
        for (int i = 0; i < LEN; i++) begin
            x = int'(a[i*BW +: BW]);
            y = int'(b[i*BW +: BW]);
            r[i*PW +: PW] = PW'(x * y);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input prd_t obs, input prd_t exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; scoreboard both handshakes seen just before the edge.
    task automatic step();
        prd_t e;
        if (o_valid && i_ready) begin
            chk("sb_has_entry", prd_t'(q.size() != 0), prd_t'(1));
            if (q.size() != 0) begin
                e = q.pop_front();
                last_exp = e;
                chk("sb_prd", o_prd, e);
            end
        end
        hs_now = 1'b0;
        if (i_valid && o_ready && !i_clear && !i_rst) begin
            q.push_back(model(i_vec_a, i_vec_b));
            hs_gap  = cyc - last_hs;
            last_hs = cyc;
            hs_cnt++;
            hs_now  = 1'b1;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic rand_vecs();
        for (int i = 0; i < LEN; i++) begin
            i_vec_a[i*BW +: BW] = BW'($urandom_range(0, 255));
            i_vec_b[i*BW +: BW] = BW'($urandom_range(0, 255));
        end
    endtask

    // One handshake then wait (bounded) for o_valid; latency must be 4 edges.
    task automatic run_vec(input string tag);
        int n;
        i_valid = 1'b1;
        step();
        chk({tag, "_hs"}, prd_t'(hs_now), prd_t'(1));
        i_valid = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!o_valid && n < 12);
        chk({tag, "_latency"}, prd_t'(n), prd_t'(4));
    endtask

    initial begin
        prd_t e, mix;
        int   n, base;

        // reset state
        #12;
        chk("rst_ready", prd_t'(o_ready), prd_t'(1));
        chk("rst_valid", prd_t'(o_valid), prd_t'(0));
        chk("rst_busy",  prd_t'(o_busy),  prd_t'(0));
        chk("rst_prd",   o_prd, '0);
        @(negedge i_clk) i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // a[i]=i, b[i]=2
        i_ready = 1'b1;
        for (int i = 0; i < LEN; i++) begin
            i_vec_a[i*BW +: BW] = BW'(i);
            i_vec_b[i*BW +: BW] = BW'(2);
        end
        run_vec("ramp");
        e = '0;
        for (int i = 0; i < LEN; i++) e[i*PW +: PW] = PW'(2*i);
        chk("ramp_prd", o_prd, e);
        step();
        chk("ramp_busy_clr", prd_t'(o_busy),  prd_t'(0));
        chk("ramp_ready",    prd_t'(o_ready), prd_t'(1));
        chk("ramp_valid_lo", prd_t'(o_valid), prd_t'(0));

        // full-scale operands, no truncation
        i_vec_a = '1;
        i_vec_b = '1;
        run_vec("ff");
        e = {LEN{16'hFE01}};
        chk("ff_prd", o_prd, e);
        step();

        // backpressure: hold i_ready low in DONE for 10 cycles
        i_ready = 1'b0;
        rand_vecs();
        run_vec("bp");
        e = q[0];
        for (int c = 0; c < 10; c++) begin
            chk("bp_prd_stable", o_prd, e);
            chk("bp_valid",      prd_t'(o_valid), prd_t'(1));
            chk("bp_ready_lo",   prd_t'(o_ready), prd_t'(0));
            step();
        end
        i_ready = 1'b1;
        step();
        chk("bp_idle_valid", prd_t'(o_valid), prd_t'(0));
        chk("bp_idle_ready", prd_t'(o_ready), prd_t'(1));

        // clear on the third MUL cycle: chunks 0,1 updated, 2,3 keep old products
        rand_vecs();
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        mix = last_exp;
        e   = q[q.size()-1];
        mix[0 +: 2*LN*PW] = e[0 +: 2*LN*PW];
        step();
        step();
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        q.delete();
        chk("clr_busy",  prd_t'(o_busy),  prd_t'(0));
        chk("clr_ready", prd_t'(o_ready), prd_t'(1));
        chk("clr_prd_kept", o_prd, mix);
        for (int c = 0; c < 6; c++) begin
            chk("clr_no_valid", prd_t'(o_valid), prd_t'(0));
            step();
        end
        for (int i = 0; i < LEN; i++) begin
            i_vec_a[i*BW +: BW] = BW'(3);
            i_vec_b[i*BW +: BW] = BW'(5);
        end
        run_vec("after_clr");
        e = {LEN{16'd15}};
        chk("after_clr_prd", o_prd, e);
        step();

        // asynchronous reset mid-MUL
        rand_vecs();
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        step();
        #2 i_rst = 1'b1;
        #1;
        q.delete();
        chk("arst_prd",   o_prd, '0);
        chk("arst_valid", prd_t'(o_valid), prd_t'(0));
        chk("arst_busy",  prd_t'(o_busy),  prd_t'(0));
        @(negedge i_clk) i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        chk("arst_ready", prd_t'(o_ready), prd_t'(1));
        for (int c = 0; c < 6; c++) begin
            chk("arst_no_valid", prd_t'(o_valid), prd_t'(0));
            step();
        end

        // back-to-back with i_valid held high
        i_ready = 1'b1;
        rand_vecs();
        i_valid = 1'b1;
        base = hs_cnt;
        n = 0;
        while (hs_cnt < base + 6 && n < 100) begin
            step();
            n++;
            if (hs_now) begin
                if (hs_cnt > base + 1) chk("b2b_gap", prd_t'(hs_gap), prd_t'(6));
                rand_vecs();
            end
        end
        chk("b2b_count", prd_t'(hs_cnt - base), prd_t'(6));
        i_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("b2b_drained", prd_t'(q.size()), prd_t'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_mul_sched.md
VEC_MUL_SCHED -- requirements
Module: vec_mul_sched

Interface
REQ-001 The block SHALL have parameter bit_width, default 8, operand element width in bits.
REQ-002 The block SHALL have parameter length, default 32, elements per vector.
REQ-003 The block SHALL have parameter lanes, default 8, multipliers in the shared array.
REQ-004 The block SHALL have parameter prd_width, default 2*bit_width, product element width.
REQ-005 The block SHALL have port i_clk  input  1  sole clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-007 The block SHALL have port i_vec_a  input  length x bit_width  operand vector A.
REQ-008 The block SHALL have port i_vec_b  input  length x bit_width  operand vector B.
REQ-009 The block SHALL have port i_valid  input  1  operand vectors valid.
REQ-010 The block SHALL have port o_ready  output  1  block can accept operands.
REQ-011 The block SHALL have port o_prd  output  length x prd_width  registered elementwise products.
REQ-012 The block SHALL have port o_valid  output  1  o_prd valid.
REQ-013 The block SHALL have port i_ready  input  1  downstream accepts o_prd.
REQ-014 The block SHALL have port i_clear  input  1  synchronous abort; returns the block to IDLE.
REQ-015 The block SHALL have port o_busy  output  1  high when the state is not IDLE.

Function
REQ-016 The block SHALL use the states IDLE, MUL and DONE.
REQ-017 o_ready SHALL equal (state==IDLE), and an input handshake SHALL be i_valid && o_ready.
REQ-018 On an input handshake, the block SHALL capture i_vec_a and i_vec_b into operand registers, clear the chunk counter and move to MUL; inputs may change afterwards with no effect.
REQ-019 In MUL, each cycle SHALL drive chunk k (elements k*lanes .. k*lanes+lanes-1) of both operand registers into one lanes-wide multiplier array, and write the products into the matching o_prd slots at the clock edge.
REQ-020 The chunk counter SHALL be ceil-log2(length/lanes) bits wide, SHALL increment once per MUL cycle, and on its last value (length/lanes-1) SHALL wrap to 0 while the state moves to DONE.
REQ-021 Latency SHALL be fixed: with the handshake at edge T, chunks are written at edges T+1..T+length/lanes and o_valid is high from edge T+length/lanes (T+4 with defaults).
REQ-022 In DONE, o_valid SHALL be 1 and o_prd SHALL be held stable until i_ready=1; the state SHALL then return to IDLE at the next edge.
REQ-023 Throughput SHALL be at most one vector per length/lanes+2 cycles; the block SHALL NOT accept new operands in the same cycle as an output handshake.
REQ-024 Products SHALL be unsigned, full prd_width bits, and never truncated or saturated (255*255 = 65025).
REQ-025 i_clear=1 SHALL force IDLE and counter 0 at the next edge from any state, and SHALL take priority over every handshake; o_prd contents are left unchanged.
REQ-026 i_ready SHALL be ignored outside DONE, and i_valid SHALL be ignored outside IDLE.
REQ-027 length SHALL be an integer multiple of lanes; any other setting SHALL cause an elaboration-time error.

Reset
REQ-028 On i_rst=1, the block SHALL asynchronously set state=IDLE, counter=0, o_valid=0, o_busy=0, o_prd all-zero and operand registers all-zero; o_ready SHALL be 1 after reset.
REQ-029 Asserting reset mid-MUL or in DONE SHALL discard the operation with no output handshake; the first handshake after deassertion SHALL start a fresh vector.

Structure
REQ-030 A shared package SHALL hold the state enum type and the default constants (bit_width, length, lanes).
REQ-031 The lane multiplier array SHALL be one instance of the team's existing elementwise multiplier, vec_mul_i8, with length=lanes; the scheduler SHALL contain no other arithmetic.

Verification
REQ-032 Bench: a[i]=i, b[i]=2, single handshake, i_ready=1 -> o_valid rises 4 cycles after the handshake, o_prd[i]=2*i, and o_busy clears one cycle later.
REQ-033 Bench: all a=b=8'hFF -> every o_prd element = 16'hFE01.
REQ-034 Bench: hold i_ready=0 for 10 cycles in DONE -> o_prd and o_valid stable, o_ready=0 throughout; raising i_ready -> IDLE on the next edge.
REQ-035 Bench: i_clear pulsed at the third MUL cycle -> IDLE next edge, no o_valid; the next vector a=3, b=5 -> all products 15.
REQ-036 Bench: i_rst asserted asynchronously mid-MUL -> all outputs zero immediately, o_ready=1 after deassertion.
REQ-037 Bench: back-to-back i_valid held high with randomized vectors -> handshakes spaced exactly 6 cycles apart, and products match a scoreboard.
